ddr_req_queue: RTL

DDR_REQ_QUEUE -- requirements
Module: ddr_req_queue

---
 rtl/ddr_req_queue_if.sv | 57 +++++
 rtl/ddr_req_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_req_queue_if.sv
// Request/dispatch/return bundle for ddr_req_queue. The queue itself uses the
// slave view; whoever issues requests and serves the app side uses master.
interface ddr_req_queue_if #(
   parameter int ADX_W    = 27,
   parameter int DATA_W   = 128,
   parameter int APP_W    = 64,
   parameter int RD_DEPTH = 8
);
   localparam int CW = $clog2(RD_DEPTH) + 1;

   logic [ADX_W-1:0]  wr_adx_in;
   logic [DATA_W-1:0] wr_data_in;
   logic              write_req;
   logic              write_allowed;
   logic              writes_pending;
   logic [ADX_W-1:0]  rd_adx_in;
   logic              read_req;
   logic              read_allowed;
   logic              reads_pending;
   logic [ADX_W-1:0]  wr_adx_out;
   logic              has_wr_adx;
   logic              get_wr_adx;
   logic [DATA_W-1:0] wr_data_out;
   logic              has_wr_data;
   logic              get_wr_data;
   logic [ADX_W-1:0]  rd_adx_out;
   logic              has_rd_req;
   logic              get_rd_req;
   logic [APP_W-1:0]  app_rd_data;
   logic              app_rd_data_valid;
   logic [DATA_W-1:0] return_data;
   logic [ADX_W-1:0]  return_adx;
   logic              has_return_data;
   logic              get_return_data;
   logic [CW-1:0]     rd_credits;
   logic              rd_protocol_err;

   modport slave (
      input  wr_adx_in, wr_data_in, write_req, rd_adx_in, read_req,
             get_wr_adx, get_wr_data, get_rd_req,
             app_rd_data, app_rd_data_valid, get_return_data,
      output write_allowed, writes_pending, read_allowed, reads_pending,
             wr_adx_out, has_wr_adx, wr_data_out, has_wr_data,
             rd_adx_out, has_rd_req, return_data, return_adx,
             has_return_data, rd_credits, rd_protocol_err
   );

   modport master (
      output wr_adx_in, wr_data_in, write_req, rd_adx_in, read_req,
             get_wr_adx, get_wr_data, get_rd_req,
             app_rd_data, app_rd_data_valid, get_return_data,
      input  write_allowed, writes_pending, read_allowed, reads_pending,
             wr_adx_out, has_wr_adx, wr_data_out, has_wr_data,
             rd_adx_out, has_rd_req, return_data, return_adx,
             has_return_data, rd_credits, rd_protocol_err
   );
endinterface

// File: rtl/ddr_req_queue.sv
// DDR request queue: independent write address/data queues, credit-limited
// read path with read-after-write blocking, beat assembly and return queue.

// Show-ahead FIFO; the caller only pushes when there is room and only pops
// when the queue holds something.
module ddr_req_queue_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; the count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

module ddr_req_queue #(
   parameter int ADX_W    = 27,
   parameter int DATA_W   = 128,
   parameter int APP_W    = 64,
   parameter int WR_DEPTH = 8,
   parameter int RD_DEPTH = 8
) (
   input logic          clk,
   input logic          resetn,
   ddr_req_queue_if.slave q
);
   localparam int BEATS = DATA_W / APP_W;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAW   = $clog2(WR_DEPTH);
   localparam int RAW   = $clog2(RD_DEPTH);
   localparam logic [WAW:0] WR_FULL  = (WAW+1)'(WR_DEPTH);
   localparam logic [RAW:0] RD_FULL  = (RAW+1)'(RD_DEPTH);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   // Write address queue kept inline: the hazard check must see every entry.
   logic [ADX_W-1:0] r_wa_mem [WR_DEPTH];
   logic [WAW-1:0]   r_wa_rd;
   logic [WAW-1:0]   r_wa_wr;
   logic [WAW:0]     r_wa_cnt;

   logic [WAW:0]     w_wd_cnt;
   logic [RAW:0]     w_rc_cnt;
   logic [RAW:0]     w_fl_cnt;
   logic [RAW:0]     w_rt_cnt;
   logic [ADX_W-1:0] w_rc_head;
   logic [ADX_W-1:0] w_fl_head;
   logic [DATA_W+ADX_W-1:0] w_rt_head;

   logic [RAW:0]     r_credits;
   logic [BCW-1:0]   r_beat;
   logic             r_err;
   logic [BEATS-1:0][APP_W-1:0] r_acc;
   logic [BEATS-1:0][APP_W-1:0] w_ret_word;

   logic w_wr_acc, w_wa_pop, w_wd_pop, w_rd_acc, w_rc_pop, w_ret_pop;
   logic w_beat_ok, w_final, w_hazard;
   logic [WAW-1:0] w_off;

   assign q.write_allowed = (r_wa_cnt < WR_FULL) & (w_wd_cnt < WR_FULL);
   assign q.has_wr_adx    = (r_wa_cnt != '0);
   assign q.has_wr_data   = (w_wd_cnt != '0);
   assign q.writes_pending = q.has_wr_adx | q.has_wr_data;
   assign q.wr_adx_out    = r_wa_mem[r_wa_rd];

   assign w_wr_acc  = q.write_req & q.write_allowed;
   assign w_wa_pop  = q.get_wr_adx & q.has_wr_adx;
   assign w_wd_pop  = q.get_wr_data & q.has_wr_data;
   assign w_rd_acc  = q.read_req & q.read_allowed;
   assign w_rc_pop  = q.get_rd_req & q.has_rd_req;
   assign w_ret_pop = q.get_return_data & q.has_return_data;

   assign q.rd_credits    = r_credits;
   assign q.read_allowed  = (r_credits != '0);
   assign q.reads_pending = (r_credits != RD_FULL);
   assign q.rd_adx_out    = w_rc_head;
   assign q.has_rd_req    = (w_rc_cnt != '0) & ~w_hazard;
   assign q.has_return_data = (w_rt_cnt != '0);
   assign q.return_data   = w_rt_head[DATA_W+ADX_W-1:ADX_W];
   assign q.return_adx    = w_rt_head[ADX_W-1:0];
   assign q.rd_protocol_err = r_err;

   assign w_beat_ok = q.app_rd_data_valid & (w_fl_cnt != '0);
   assign w_final   = w_beat_ok & (r_beat == LAST_BEAT);

   // Write address queue pointers and count.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wa_rd  <= '0;
         r_wa_wr  <= '0;
         r_wa_cnt <= '0;
      end else begin
         if (w_wr_acc) r_wa_wr <= r_wa_wr + 1'b1;
         if (w_wa_pop) r_wa_rd <= r_wa_rd + 1'b1;
         case ({w_wr_acc, w_wa_pop})
            2'b10:   r_wa_cnt <= r_wa_cnt + 1'b1;
            2'b01:   r_wa_cnt <= r_wa_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // Write address storage.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_wa_mem[r_wa_wr] <= q.wr_adx_in;
   end

   // Read head blocked while any live or incoming write targets the same address.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_off    = '0;
      w_hazard = w_wr_acc & (q.wr_adx_in == w_rc_head);
      for (int i = 0; i < WR_DEPTH; i++) begin
         w_off = WAW'(i) - r_wa_rd;
         if (({1'b0, w_off} < r_wa_cnt) && (r_wa_mem[i] == w_rc_head))
            w_hazard = 1'b1;
      end
   end

   // Credits leave on an accepted read and come back when the consumer pops.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_credits <= RD_FULL;
      end else begin
         case ({w_rd_acc, w_ret_pop})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: ;
         endcase
      end
   end

   // Beat counter and sticky error for beats with nothing in flight.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_beat <= '0;
         r_err  <= 1'b0;
      end else begin
         if (q.app_rd_data_valid && (w_fl_cnt == '0)) r_err <= 1'b1;
         if (w_beat_ok) r_beat <= w_final ? '0 : r_beat + 1'b1;
      end
   end

   // Partial-word accumulator; the final beat bypasses it straight to the queue.
   always_ff @(posedge clk) begin
      if (w_beat_ok && !w_final) r_acc[r_beat] <= q.app_rd_data;
   end

   // Completed word: earlier beats from the accumulator, last beat on top.
   always_comb begin
      w_ret_word            = r_acc;
      w_ret_word[BEATS-1]   = q.app_rd_data;
   end

   ddr_req_queue_fifo #(.W(DATA_W), .DEPTH(WR_DEPTH)) u_wr_data (
      .clk(clk), .resetn(resetn), .i_push(w_wr_acc), .i_data(q.wr_data_in),
      .i_pop(w_wd_pop), .o_data(q.wr_data_out), .o_count(w_wd_cnt)
   );

   ddr_req_queue_fifo #(.W(ADX_W), .DEPTH(RD_DEPTH)) u_rd_cmd (
      .clk(clk), .resetn(resetn), .i_push(w_rd_acc), .i_data(q.rd_adx_in),
      .i_pop(w_rc_pop), .o_data(w_rc_head), .o_count(w_rc_cnt)
   );

   ddr_req_queue_fifo #(.W(ADX_W), .DEPTH(RD_DEPTH)) u_in_flight (
      .clk(clk), .resetn(resetn), .i_push(w_rc_pop), .i_data(w_rc_head),
      .i_pop(w_final), .o_data(w_fl_head), .o_count(w_fl_cnt)
   );

   ddr_req_queue_fifo #(.W(DATA_W+ADX_W), .DEPTH(RD_DEPTH)) u_return (
      .clk(clk), .resetn(resetn), .i_push(w_final), .i_data({w_ret_word, w_fl_head}),
      .i_pop(w_ret_pop), .o_data(w_rt_head), .o_count(w_rt_cnt)
   );
endmodule
